lcd_cmd_arbiter: RTL

Shares the single PMOD CLS LCD driver command interface between two requesters. Requester A is the periodic text feed. Requester B is the alert/status feed. The arbiter grants the driver to one requester for a whole locked transaction (clear, line 1, line 2), muxes that requester's commands and 2x16-byte text buffers to the driver, and enforces a drain gap between owners. It sits between the text-feed FSMs and the LCD SPI driver, in the 20 MHz domain, stepping on the 2.5 MHz clock enable.

---
 rtl/lcd_arb_pkg.sv | 27 ++
 rtl/lcd_arb_mux.sv | 48 ++++
 rtl/lcd_cmd_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types for the LCD command arbiter: FSM states, owner codes and text-line helpers.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_OWN_A = 2'd1,
    ST_ARB_OWN_B = 2'd2,
    ST_ARB_DRAIN = 2'd3
  } t_arb_state;

  typedef logic [1:0] t_arb_owner;
  localparam t_arb_owner OWNER_NONE = 2'b00;
  localparam t_arb_owner OWNER_A    = 2'b01;
  localparam t_arb_owner OWNER_B    = 2'b10;

  typedef logic [127:0] t_lcd_line;
  localparam t_lcd_line c_lcd_blank_line = {16{8'h20}};

  function automatic t_arb_owner owner_of_state(input t_arb_state s);
    case (s)
      ST_ARB_OWN_A: return OWNER_A;
      ST_ARB_OWN_B: return OWNER_B;
      default:      return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_arb_mux.sv
// Owner-select of the driver command strobes and text lines; blank lines and no strobes when unowned.
module lcd_arb_mux
  import lcd_arb_pkg::*;
(
  input  logic [1:0]   owner,
  input  logic         wr_clear_a,
  input  logic         wr_line1_a,
  input  logic         wr_line2_a,
  input  logic         wr_clear_b,
  input  logic         wr_line1_b,
  input  logic         wr_line2_b,
  input  logic [127:0] line1_a,
  input  logic [127:0] line2_a,
  input  logic [127:0] line1_b,
  input  logic [127:0] line2_b,
  output logic         wr_clear,
  output logic         wr_line1,
  output logic         wr_line2,
  output logic [127:0] line1,
  output logic [127:0] line2
);

  always_comb begin
    wr_clear = 1'b0;
    wr_line1 = 1'b0;
    wr_line2 = 1'b0;
    line1    = c_lcd_blank_line;
    line2    = c_lcd_blank_line;
    case (owner)
      OWNER_A: begin
        wr_clear = wr_clear_a;
        wr_line1 = wr_line1_a;
        wr_line2 = wr_line2_a;
        line1    = line1_a;
        line2    = line2_a;
      end
      OWNER_B: begin
        wr_clear = wr_clear_b;
        wr_line1 = wr_line1_b;
        wr_line2 = wr_line2_b;
        line1    = line1_b;
        line2    = line2_b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Two-requester arbiter for the PMOD CLS LCD driver: whole-transaction grants with a drain gap.
// Optional grant watchdog with sticky fault flag: define LCD_ARB_WATCHDOG_EN.
module lcd_cmd_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int parm_round_robin    = 0,
  parameter int parm_drain_cycles   = 4,
  parameter int parm_watchdog_ticks = 2500000
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rstn_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_lcd_command_ready,
  input  logic         i_req_a,
  input  logic         i_req_b,
  output logic         o_gnt_a,
  output logic         o_gnt_b,
  input  logic         i_wr_clear_a,
  input  logic         i_wr_clear_b,
  input  logic         i_wr_line1_a,
  input  logic         i_wr_line1_b,
  input  logic         i_wr_line2_a,
  input  logic         i_wr_line2_b,
  input  logic [127:0] i_line1_a,
  input  logic [127:0] i_line1_b,
  input  logic [127:0] i_line2_a,
  input  logic [127:0] i_line2_b,
  output logic         o_lcd_command_ready_a,
  output logic         o_lcd_command_ready_b,
  output logic         o_lcd_wr_clear_display,
  output logic         o_lcd_wr_text_line1,
  output logic         o_lcd_wr_text_line2,
  output logic [127:0] o_dat_ascii_line1,
  output logic [127:0] o_dat_ascii_line2,
  output logic [1:0]   o_arb_owner,
  output logic         o_arb_fault
);

  if (parm_drain_cycles < 1 || parm_drain_cycles > 15 || parm_watchdog_ticks < 1) begin : g_bad_params
    $error("lcd_cmd_arbiter: parameter out of range");
  end

  localparam logic [3:0] c_drain_last = 4'(parm_drain_cycles - 1);

  t_arb_state state_q, state_d;
  t_arb_owner last_q, last_d;
  t_arb_owner owner;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       wd_fire;
  logic       elig_a, elig_b;

  assign owner       = owner_of_state(state_q);
  assign o_arb_owner = owner;
  assign o_gnt_a     = (state_q == ST_ARB_OWN_A);
  assign o_gnt_b     = (state_q == ST_ARB_OWN_B);
  assign o_lcd_command_ready_a = i_lcd_command_ready & o_gnt_a;
  assign o_lcd_command_ready_b = i_lcd_command_ready & o_gnt_b;

`ifdef LCD_ARB_WATCHDOG_EN
  localparam logic [23:0] c_wd_last = 24'(parm_watchdog_ticks - 1);

  logic [23:0] hold_q;
  logic        fault_q, block_a_q, block_b_q;

  assign wd_fire     = (o_gnt_a | o_gnt_b) && (hold_q == c_wd_last);
  assign elig_a      = i_req_a & ~block_a_q;
  assign elig_b      = i_req_b & ~block_b_q;
  assign o_arb_fault = fault_q;

  // Hold time is measured from grant; a forced-out requester stays locked out until it lets go.
  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      hold_q    <= '0;
      fault_q   <= 1'b0;
      block_a_q <= 1'b0;
      block_b_q <= 1'b0;
    end else if (i_ce_2_5mhz) begin
      if (!(o_gnt_a | o_gnt_b))
        hold_q <= '0;
      else if (hold_q != '1)
        hold_q <= hold_q + 24'd1;
      if (wd_fire)
        fault_q <= 1'b1;
      if (wd_fire && o_gnt_a && i_req_a)
        block_a_q <= 1'b1;
      else if (!i_req_a)
        block_a_q <= 1'b0;
      if (wd_fire && o_gnt_b && i_req_b)
        block_b_q <= 1'b1;
      else if (!i_req_b)
        block_b_q <= 1'b0;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign elig_a      = i_req_a;
  assign elig_b      = i_req_b;
  assign o_arb_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_ARB_IDLE: begin
        if (i_lcd_command_ready) begin
          if (elig_a && elig_b) begin
            if (parm_round_robin != 0 && last_q == OWNER_B)
              state_d = ST_ARB_OWN_A;
            else
              state_d = ST_ARB_OWN_B;
          end else if (elig_a) begin
            state_d = ST_ARB_OWN_A;
          end else if (elig_b) begin
            state_d = ST_ARB_OWN_B;
          end
        end
      end
      ST_ARB_OWN_A: begin
        if (!i_req_a || wd_fire) begin
          state_d = ST_ARB_DRAIN;
          last_d  = OWNER_A;
        end
      end
      ST_ARB_OWN_B: begin
        if (!i_req_b || wd_fire) begin
          state_d = ST_ARB_DRAIN;
          last_d  = OWNER_B;
        end
      end
      default: begin
        // The gap only counts consecutive ready ticks; any busy tick restarts it.
        if (!i_lcd_command_ready) begin
          drain_cnt_d = 4'd0;
        end else if (drain_cnt_q == c_drain_last) begin
          drain_cnt_d = 4'd0;
          state_d     = ST_ARB_IDLE;
        end else if (drain_cnt_q != 4'hF) begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q     <= ST_ARB_DRAIN;
      last_q      <= OWNER_A;
      drain_cnt_q <= 4'd0;
    end else if (i_ce_2_5mhz) begin
      state_q     <= state_d;
      last_q      <= last_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  lcd_arb_mux u_mux (
    .owner      (owner),
    .wr_clear_a (i_wr_clear_a),
    .wr_line1_a (i_wr_line1_a),
    .wr_line2_a (i_wr_line2_a),
    .wr_clear_b (i_wr_clear_b),
    .wr_line1_b (i_wr_line1_b),
    .wr_line2_b (i_wr_line2_b),
    .line1_a    (i_line1_a),
    .line2_a    (i_line2_a),
    .line1_b    (i_line1_b),
    .line2_b    (i_line2_b),
    .wr_clear   (o_lcd_wr_clear_display),
    .wr_line1   (o_lcd_wr_text_line1),
    .wr_line2   (o_lcd_wr_text_line2),
    .line1      (o_dat_ascii_line1),
    .line2      (o_dat_ascii_line2)
  );

endmodule
